// File: rtl/bus_copy_engine.sv
// bus_copy_engine: word-by-word memory copy over a single valid/ready bus.
// Each word is read from the source, held in a one-word buffer, then written
// to the destination. The bus is idled for at least one cycle between
// transfers, and completion is reported by a done pulse and a sticky irq.
module bus_copy_engine #(
  parameter int LENGTH_WIDTH = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic [31:0]             src_address_i,
  input  logic [31:0]             dst_address_i,
  input  logic [LENGTH_WIDTH-1:0] length_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    irq_o,
  input  logic                    irq_ack_i,
  output logic                    valid_o,
  output logic [31:0]             address_o,
  output logic [3:0]              wstrobe_o,
  output logic [31:0]             wdata_o,
  input  logic [31:0]             rdata_i,
  input  logic                    ready_i
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_GAP   = 3'd2,
    S_WRITE = 3'd3,
    S_NEXT  = 3'd4
  } state_e;

  // Byte addresses are used as word addresses: the two low bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

  state_e                  state_q,     state_d;
  logic [31:0]             src_q,       src_d;
  logic [31:0]             dst_q,       dst_d;
  logic [LENGTH_WIDTH-1:0] remaining_q, remaining_d;
  logic [31:0]             buf_q,       buf_d;
  logic                    valid_q,     valid_d;
  logic [31:0]             address_q,   address_d;
  logic [3:0]              wstrobe_q,   wstrobe_d;
  logic [31:0]             wdata_q,     wdata_d;
  logic                    busy_q,      busy_d;
  logic                    done_q,      done_d;
  logic                    irq_q,       irq_d;
  logic                    irq_set;
  logic                    bus_xfer;

  // A transfer only completes while we are actually requesting; a stray
  // ready with valid low is ignored.
  assign bus_xfer = valid_q & ready_i;

  // Next-state and next-output computation for the copy sequencer.
  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    remaining_d = remaining_q;
    buf_d       = buf_q;
    valid_d     = valid_q;
    address_d   = address_q;
    wstrobe_d   = wstrobe_q;
    wdata_d     = wdata_q;
    done_d      = 1'b0;
    irq_set     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (length_i != '0) begin
            src_d       = word_align(src_address_i);
            dst_d       = word_align(dst_address_i);
            remaining_d = length_i;
            state_d     = S_READ;
            valid_d     = 1'b1;
            wstrobe_d   = 4'h0;
            address_d   = word_align(src_address_i);
          end else begin
            // Empty copy: report completion without touching the bus.
            done_d  = 1'b1;
            irq_set = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_READ: begin
        if (bus_xfer) begin
          buf_d   = rdata_i;
          valid_d = 1'b0;
          state_d = S_GAP;
        end else begin
          state_d = S_READ;
        end
      end

      S_GAP: begin
        state_d   = S_WRITE;
        valid_d   = 1'b1;
        wstrobe_d = 4'hF;
        address_d = dst_q;
        wdata_d   = buf_q;
      end

      S_WRITE: begin
        if (bus_xfer) begin
          remaining_d = remaining_q - LENGTH_WIDTH'(1);
          valid_d     = 1'b0;
          wstrobe_d   = 4'h0;
          if (remaining_q <= LENGTH_WIDTH'(1)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            irq_set = 1'b1;
          end else begin
            state_d = S_NEXT;
          end
        end else begin
          state_d = S_WRITE;
        end
      end

      S_NEXT: begin
        // 32-bit addition wraps naturally at the top of the address space.
        src_d     = src_q + 32'd4;
        dst_d     = dst_q + 32'd4;
        state_d   = S_READ;
        valid_d   = 1'b1;
        wstrobe_d = 4'h0;
        address_d = src_q + 32'd4;
      end

      default: begin
        state_d   = S_IDLE;
        valid_d   = 1'b0;
        wstrobe_d = 4'h0;
      end
    endcase

    // Completion has priority over an acknowledge in the same cycle.
    irq_d  = irq_set ? 1'b1 : (irq_ack_i ? 1'b0 : irq_q);
    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs; reset clears everything asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      src_q       <= 32'h0;
      dst_q       <= 32'h0;
      remaining_q <= '0;
      buf_q       <= 32'h0;
      valid_q     <= 1'b0;
      address_q   <= 32'h0;
      wstrobe_q   <= 4'h0;
      wdata_q     <= 32'h0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      remaining_q <= remaining_d;
      buf_q       <= buf_d;
      valid_q     <= valid_d;
      address_q   <= address_d;
      wstrobe_q   <= wstrobe_d;
      wdata_q     <= wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      irq_q       <= irq_d;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign irq_o     = irq_q;
  assign valid_o   = valid_q;
  assign address_o = address_q;
  assign wstrobe_o = wstrobe_q;
  assign wdata_o   = wdata_q;

endmodule

// File: tb/tb_bus_copy_engine.sv
// Bench for bus_copy_engine: a memory responder with random latencies, a
// transaction-level copy model (expected list of reads/writes per accepted
// start) checked every cycle, and directed scenarios pinned with literals.
module tb_bus_copy_engine;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          start_i;
  logic [31:0]   src_address_i, dst_address_i;
  logic [LW-1:0] length_i;
  logic          busy_o, done_o, irq_o, irq_ack_i;
  logic          valid_o;
  logic [31:0]   address_o, wdata_o, rdata_i;
  logic [3:0]    wstrobe_o;
  logic          ready_i, ready_drv;

  // responder configuration
  bit wr_comb;
  bit stray_en;
  int rd_lat_fixed;

  always #5 clk = ~clk;

  assign ready_i = ready_drv | (valid_o && (wstrobe_o == 4'hF) && wr_comb);

  bus_copy_engine #(.LENGTH_WIDTH(LW)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i),
    .src_address_i(src_address_i), .dst_address_i(dst_address_i),
    .length_i(length_i), .busy_o(busy_o), .done_o(done_o), .irq_o(irq_o),
    .irq_ack_i(irq_ack_i), .valid_o(valid_o), .address_o(address_o),
    .wstrobe_o(wstrobe_o), .wdata_o(wdata_o), .rdata_i(rdata_i),
    .ready_i(ready_i)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- memory ----------------
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] memval(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
  endfunction

  // ---------------- copy model ----------------
  typedef struct { bit wr; logic [31:0] addr; } xfer_t;
  xfer_t       exp_q[$];
  logic [31:0] rd_log[$];
  int          wr_total = 0;
  bit          exp_busy, exp_done, exp_irq;
  bit          prev_valid, prev_fire;
  logic [31:0] prev_addr, prev_wdata, last_rdata;
  logic [3:0]  prev_strb;

  // Single compare process: every negedge, DUT outputs versus the model.
  initial begin : compare
    bit    fire, nxt_done, nxt_busy, set;
    xfer_t h;
    exp_busy = 0; exp_done = 0; exp_irq = 0; prev_valid = 0; prev_fire = 0;
    last_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        chk("rst_valid", valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_irq", irq_o, 0);
        chk("rst_address", address_o, 0);
        chk("rst_wstrobe", wstrobe_o, 0);
        chk("rst_wdata", wdata_o, 0);
        exp_q.delete();
        exp_busy = 0; exp_done = 0; exp_irq = 0; prev_valid = 0; prev_fire = 0;
      end else begin
        chk("busy", busy_o, exp_busy);
        chk("done", done_o, exp_done);
        chk("irq", irq_o, exp_irq);
        if (valid_o) begin
          chk("valid_only_when_busy", 1, exp_busy);
          chk("addr_aligned", address_o[1:0], 0);
          chk("wstrobe_legal", (wstrobe_o == 4'h0) || (wstrobe_o == 4'hF), 1);
        end
        if (prev_valid && !prev_fire) begin
          chk("hold_valid", valid_o, 1);
          chk("hold_addr", address_o, prev_addr);
          chk("hold_wstrobe", wstrobe_o, prev_strb);
          chk("hold_wdata", wdata_o, prev_wdata);
        end
        if (prev_fire) chk("idle_after_xfer", valid_o, 0);

        fire = valid_o && ready_i;
        nxt_done = 0; set = 0; nxt_busy = exp_busy;
        if (fire) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_xfer: addr %h wstrobe %h, expected no transfer", address_o, wstrobe_o);
          end else begin
            h = exp_q.pop_front();
            chk("xfer_is_write", wstrobe_o == 4'hF, h.wr);
            chk("xfer_addr", address_o, h.addr);
            if (h.wr) begin
              chk("xfer_wdata", wdata_o, last_rdata);
              mem[address_o] = wdata_o;
              wr_total++;
              if (exp_q.size() == 0) begin
                set = 1; nxt_done = 1; nxt_busy = 0;
              end
            end else begin
              last_rdata = rdata_i;
              rd_log.push_back(address_o);
            end
          end
        end
        if (start_i && !exp_busy) begin
          if (length_i == '0) begin
            set = 1; nxt_done = 1;
          end else begin
            for (int k = 0; k < int'(length_i); k++) begin
              exp_q.push_back('{wr: 1'b0, addr: (src_address_i & 32'hFFFF_FFFC) + 32'(4 * k)});
              exp_q.push_back('{wr: 1'b1, addr: (dst_address_i & 32'hFFFF_FFFC) + 32'(4 * k)});
            end
            nxt_busy = 1;
          end
        end
        exp_irq  = set ? 1'b1 : (irq_ack_i ? 1'b0 : exp_irq);
        exp_done = nxt_done;
        exp_busy = nxt_busy;
        prev_valid = valid_o; prev_fire = fire;
        prev_addr = address_o; prev_strb = wstrobe_o; prev_wdata = wdata_o;
      end
    end
  end

  // Memory responder: read/write latency counted from the first valid cycle.
  initial begin : responder
    int cnt, lat;
    cnt = 0; lat = 1; ready_drv = 1'b0; rdata_i = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (!rst_ni || !valid_o) begin
        cnt = 0;
        ready_drv = stray_en && ($urandom_range(0, 3) == 0);
        rdata_i = $urandom;
      end else begin
        if (cnt == 0) begin
          if (wstrobe_o == 4'h0) lat = (rd_lat_fixed != 0) ? rd_lat_fixed : $urandom_range(1, 4);
          else                   lat = $urandom_range(1, 3);
        end
        cnt++;
        ready_drv = (cnt >= lat);
        rdata_i = (ready_drv && wstrobe_o == 4'h0) ? memval(address_o) : $urandom;
      end
    end
  end

  // Pulse start; return posedges from the accepting edge to done visible.
  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input int l,
                          input int inject, input bit ack_rand, output int edges);
    src_address_i = s; dst_address_i = d; length_i = LW'(l); start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; edges = 0;
    if (ack_rand) irq_ack_i = ($urandom_range(0, 7) == 0);
    while (!done_o && edges < 300) begin
      @(posedge clk); #1;
      edges++;
      start_i = (edges == inject);
      if (start_i) begin
        src_address_i = $urandom; dst_address_i = $urandom;
        length_i = LW'($urandom_range(1, 5));
      end
      if (ack_rand) irq_ack_i = ($urandom_range(0, 7) == 0);
    end
    start_i = 1'b0;
    if (!done_o) begin
      n_cmp++; n_bad++;
      $display("FAIL done_timeout: done not seen after %0d cycles, expected a pulse", edges);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic ack_pulse();
    irq_ack_i = 1'b1; idle(1); irq_ack_i = 1'b0;
  endtask

  initial begin : main
    int e, base_r, base_w;
    rst_ni = 1'b0; start_i = 1'b0; irq_ack_i = 1'b0;
    src_address_i = 32'h0; dst_address_i = 32'h0; length_i = '0;
    wr_comb = 1'b1; stray_en = 1'b0; rd_lat_fixed = 2;
    repeat (3) @(posedge clk);
    #1 rst_ni = 1'b1;
    idle(2);

    // three-word copy, 2-cycle read / 0-cycle write
    mem[32'h100] = 32'hA; mem[32'h104] = 32'hB; mem[32'h108] = 32'hC;
    base_r = rd_log.size();
    run_copy(32'h100, 32'h200, 3, 0, 0, e);
    chk("s1_done_latency", e, 14);
    chk("s1_rd0", rd_log[base_r], 32'h100);
    chk("s1_rd1", rd_log[base_r+1], 32'h104);
    chk("s1_rd2", rd_log[base_r+2], 32'h108);
    chk("s1_wr0", memval(32'h200), 32'hA);
    chk("s1_wr1", memval(32'h204), 32'hB);
    chk("s1_wr2", memval(32'h208), 32'hC);
    chk("s1_irq", irq_o, 1);
    idle(1);
    chk("s1_done_single", done_o, 0);
    ack_pulse(); idle(1);

    // zero-length copy
    chk("s2_irq_before", irq_o, 0);
    base_r = rd_log.size();
    run_copy(32'h40, 32'h80, 0, 0, 0, e);
    chk("s2_done_latency", e, 0);
    chk("s2_irq", irq_o, 1);
    idle(3);
    chk("s2_no_reads", rd_log.size() - base_r, 0);
    ack_pulse(); idle(1);

    // source wraps at the top of the address space
    base_r = rd_log.size();
    run_copy(32'hFFFF_FFFD, 32'h3000, 2, 0, 0, e);
    chk("s4_rd0", rd_log[base_r], 32'hFFFF_FFFC);
    chk("s4_rd1", rd_log[base_r+1], 32'h0000_0000);
    idle(2);

    // start re-pulsed during a two-word copy
    base_r = rd_log.size(); base_w = wr_total;
    run_copy(32'h400, 32'h500, 2, 2, 0, e);
    idle(10);
    chk("s3_reads", rd_log.size() - base_r, 2);
    chk("s3_writes", wr_total - base_w, 2);
    chk("s3_rd1", rd_log[base_r+1], 32'h404);
    chk("s3_wr1", memval(32'h504), memval(32'h404));
    ack_pulse(); idle(1);

    // reset while a read waits for ready
    rd_lat_fixed = 4;
    base_r = rd_log.size(); base_w = wr_total;
    src_address_i = 32'h800; dst_address_i = 32'h900; length_i = LW'(2); start_i = 1'b1;
    idle(1); start_i = 1'b0;
    chk("s5_valid_before", valid_o, 1);
    idle(1);
    rst_ni = 1'b0; #1;
    chk("s5_valid_in_reset", valid_o, 0);
    chk("s5_busy_in_reset", busy_o, 0);
    idle(2);
    rst_ni = 1'b1;
    idle(15);
    chk("s5_no_reads", rd_log.size() - base_r, 0);
    chk("s5_no_writes", wr_total - base_w, 0);
    chk("s5_irq", irq_o, 0);
    rd_lat_fixed = 2;

    // irq_ack held across the completing cycle
    irq_ack_i = 1'b1;
    run_copy(32'hA00, 32'hB00, 1, 0, 0, e);
    irq_ack_i = 1'b0;
    chk("s6_irq_set_wins", irq_o, 1);
    idle(1);
    chk("s6_irq_sticky", irq_o, 1);
    ack_pulse();
    chk("s6_irq_cleared", irq_o, 0);

    // randomized copies
    rd_lat_fixed = 0; stray_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      int len, inj;
      logic [31:0] s, d;
      wr_comb = $urandom_range(0, 1);
      len = $urandom_range(1, 6);
      inj = (len >= 2 && $urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
      s = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
      d = $urandom;
      run_copy(s, d, len, inj, 1, e);
      idle($urandom_range(0, 3));
    end
    irq_ack_i = 1'b0; stray_en = 1'b0;
    idle(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
